register_bank_dumper: RTL

- Reader-side companion to `register_bank`. On a start pulse, it walks every register through the bank's rx read port (`reg_selector` → `reg_data`).
- It streams a framed snapshot to a downstream byte sink (UART tx / debug port) over a valid/ready handshake.
- Frame format: header byte, then R0..R(N-1), then an XOR checksum.
- Sits beside the CPU datapath. It only drives the read selector and never writes the bank.

---
 rtl/register_bank_dumper.sv | 116 +++++++++++
 1 files changed

// File: rtl/register_bank_dumper.sv
// Walks every register of a register_bank through its rx read port and streams
// a framed snapshot (header, R0..R(N-1), XOR checksum) over a valid/ready link.
module register_bank_dumper #(
  parameter int unsigned              NUM_REGS   = 8,
  parameter int unsigned              DATA_WIDTH = 8,
  parameter int unsigned              SEL_WIDTH  = 3,
  parameter logic [DATA_WIDTH-1:0]    HEADER     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [SEL_WIDTH-1:0]  reg_selector,
  input  logic [DATA_WIDTH-1:0] reg_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    SEND,
    CSUM,
    DONE
  } state_t;

  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_REGS - 1);

  state_t                  state_q;
  logic [SEL_WIDTH-1:0]    idx_q;
  logic [DATA_WIDTH-1:0]   checksum_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    xfer;

  assign xfer         = out_valid_q && out_ready;
  assign busy         = busy_q;
  assign done         = done_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign reg_selector = idx_q;

  // The selector is idx itself, so the bank is addressed during LOAD and the
  // captured byte is frozen in out_data_q for the whole SEND handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      checksum_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= HDR;
            idx_q       <= '0;
            checksum_q  <= '0;
            out_data_q  <= HEADER;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        HDR: begin
          if (xfer) begin
            state_q     <= LOAD;
            out_valid_q <= 1'b0;
          end
        end
        LOAD: begin
          out_data_q  <= reg_data;
          checksum_q  <= checksum_q ^ reg_data;
          out_valid_q <= 1'b1;
          state_q     <= SEND;
        end
        SEND: begin
          if (xfer) begin
            if (idx_q == LAST_IDX) begin
              state_q    <= CSUM;
              out_data_q <= checksum_q;
            end else begin
              idx_q       <= idx_q + 1'b1;
              out_valid_q <= 1'b0;
              state_q     <= LOAD;
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            state_q     <= DONE;
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
